// File: rtl/msg_decrypt_if.sv
//------------------------------------------------------------------------------
// Module      : msg_decrypt_if
// Description : Control and memory-bus bundle for the RC4 message decryptor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface msg_decrypt_if;
  logic       state_start;
  logic [7:0] s_q;
  logic [7:0] rom_q;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wen;
  logic [7:0] rom_address;
  logic [7:0] d_address;
  logic [7:0] d_data;
  logic       d_wen;
  logic [1:0] memory_sel;
  logic       dec_mem_handler;
  logic       finish;
  logic       key_invalid;

  // Decryptor side: drives the three memory buses and status.
  modport master (
    input  state_start, s_q, rom_q,
    output s_address, s_data, s_wen, rom_address, d_address, d_data, d_wen,
           memory_sel, dec_mem_handler, finish, key_invalid
  );

  // Environment side: memories and the sequencer that issues state_start.
  modport slave (
    output state_start, s_q, rom_q,
    input  s_address, s_data, s_wen, rom_address, d_address, d_data, d_wen,
           memory_sel, dec_mem_handler, finish, key_invalid
  );
endinterface

`default_nettype wire

// File: rtl/msg_decrypt.sv
//------------------------------------------------------------------------------
// Module      : msg_decrypt
// Description : RC4 keystream decryption of a ROM message into a RAM, aborting
//               on the first non-printable byte.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module msg_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  msg_decrypt_if.master   bus
);

  localparam logic [8:0] c_last = 9'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_I   = 4'd1,
    WAIT_I = 4'd2,
    CAP_I  = 4'd3,
    RD_J   = 4'd4,
    WAIT_J = 4'd5,
    CAP_J  = 4'd6,
    WR_I   = 4'd7,
    WR_J   = 4'd8,
    RD_F   = 4'd9,
    WAIT_F = 4'd10,
    CAP_F  = 4'd11,
    WR_D   = 4'd12,
    NEXT   = 4'd13,
    DONE   = 4'd14
  } state_t;

  state_t     r_state, w_state;
  logic [7:0] r_i, w_i;
  logic [7:0] r_j, w_j;
  logic [8:0] r_k, w_k;
  logic [7:0] r_si, w_si;
  logic [7:0] r_sj, w_sj;
  logic [7:0] r_out, w_out;
  logic       r_bad, w_bad;
  logic [7:0] r_s_address, w_s_address;
  logic [7:0] r_s_data, w_s_data;
  logic       r_s_wen, w_s_wen;
  logic [7:0] r_rom_address, w_rom_address;
  logic [7:0] r_d_address, w_d_address;
  logic [7:0] r_d_data, w_d_data;
  logic       r_d_wen, w_d_wen;
  logic [1:0] r_memory_sel, w_memory_sel;
  logic       r_dec_mem_handler, w_dec_mem_handler;
  logic       r_finish, w_finish;
  logic       r_key_invalid, w_key_invalid;
  logic       w_printable;

  assign w_printable = (r_out == 8'h20) || ((r_out >= 8'h61) && (r_out <= 8'h7A));

  always_comb begin
    w_state           = r_state;
    w_i               = r_i;
    w_j               = r_j;
    w_k               = r_k;
    w_si              = r_si;
    w_sj              = r_sj;
    w_out             = r_out;
    w_bad             = r_bad;
    w_s_address       = r_s_address;
    w_s_data          = r_s_data;
    w_s_wen           = 1'b0;
    w_rom_address     = r_rom_address;
    w_d_address       = r_d_address;
    w_d_data          = r_d_data;
    w_d_wen           = 1'b0;
    w_memory_sel      = r_memory_sel;
    w_dec_mem_handler = r_dec_mem_handler;
    w_finish          = r_finish;
    w_key_invalid     = r_key_invalid;

    if (bus.state_start) begin
      w_state           = RD_I;
      w_i               = 8'd1;
      w_j               = 8'd0;
      w_k               = 9'd0;
      w_finish          = 1'b0;
      w_key_invalid     = 1'b0;
      w_dec_mem_handler = 1'b1;
      w_memory_sel      = 2'b10;
    end else begin
      // Each state's register updates land on the edge that leaves it, so a
      // read address set in RD_x is sampled back two edges later in CAP_x.
      case (r_state)
        RD_I:   begin w_s_address = r_i; w_state = WAIT_I; end
        WAIT_I: w_state = CAP_I;
        CAP_I:  begin w_si = bus.s_q; w_j = r_j + bus.s_q; w_state = RD_J; end
        RD_J:   begin w_s_address = r_j; w_state = WAIT_J; end
        WAIT_J: w_state = CAP_J;
        CAP_J:  begin w_sj = bus.s_q; w_state = WR_I; end
        WR_I: begin
          w_s_address = r_i;
          w_s_data    = r_sj;
          w_s_wen     = 1'b1;
          w_state     = WR_J;
        end
        WR_J: begin
          w_s_address = r_j;
          w_s_data    = r_si;
          w_s_wen     = 1'b1;
          w_state     = RD_F;
        end
        RD_F: begin
          w_s_address   = r_si + r_sj;
          w_rom_address = r_k[7:0];
          w_state       = WAIT_F;
        end
        WAIT_F: w_state = CAP_F;
        CAP_F:  begin w_out = bus.s_q ^ bus.rom_q; w_state = WR_D; end
        WR_D: begin
          w_d_address = r_k[7:0];
          w_d_data    = r_out;
          w_d_wen     = 1'b1;
          w_bad       = !w_printable;
          w_state     = NEXT;
        end
        NEXT: begin
          if (r_bad || (r_k == c_last)) begin
            w_key_invalid     = r_bad;
            w_finish          = 1'b1;
            w_dec_mem_handler = 1'b0;
            w_memory_sel      = 2'b00;
            w_state           = DONE;
          end else begin
            w_k     = r_k + 9'd1;
            w_i     = r_i + 8'd1;
            w_state = RD_I;
          end
        end
        IDLE:    w_state = IDLE;
        DONE:    w_state = DONE;
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_i               <= 8'd0;
      r_j               <= 8'd0;
      r_k               <= 9'd0;
      r_si              <= 8'd0;
      r_sj              <= 8'd0;
      r_out             <= 8'd0;
      r_bad             <= 1'b0;
      r_s_address       <= 8'd0;
      r_s_data          <= 8'd0;
      r_s_wen           <= 1'b0;
      r_rom_address     <= 8'd0;
      r_d_address       <= 8'd0;
      r_d_data          <= 8'd0;
      r_d_wen           <= 1'b0;
      r_memory_sel      <= 2'b00;
      r_dec_mem_handler <= 1'b0;
      r_finish          <= 1'b0;
      r_key_invalid     <= 1'b0;
    end else begin
      r_state           <= w_state;
      r_i               <= w_i;
      r_j               <= w_j;
      r_k               <= w_k;
      r_si              <= w_si;
      r_sj              <= w_sj;
      r_out             <= w_out;
      r_bad             <= w_bad;
      r_s_address       <= w_s_address;
      r_s_data          <= w_s_data;
      r_s_wen           <= w_s_wen;
      r_rom_address     <= w_rom_address;
      r_d_address       <= w_d_address;
      r_d_data          <= w_d_data;
      r_d_wen           <= w_d_wen;
      r_memory_sel      <= w_memory_sel;
      r_dec_mem_handler <= w_dec_mem_handler;
      r_finish          <= w_finish;
      r_key_invalid     <= w_key_invalid;
    end
  end

  assign bus.s_address       = r_s_address;
  assign bus.s_data          = r_s_data;
  assign bus.s_wen           = r_s_wen;
  assign bus.rom_address     = r_rom_address;
  assign bus.d_address       = r_d_address;
  assign bus.d_data          = r_d_data;
  assign bus.d_wen           = r_d_wen;
  assign bus.memory_sel      = r_memory_sel;
  assign bus.dec_mem_handler = r_dec_mem_handler;
  assign bus.finish          = r_finish;
  assign bus.key_invalid     = r_key_invalid;

endmodule

`default_nettype wire

// File: tb/tb_msg_decrypt.sv
//------------------------------------------------------------------------------
// Module      : tb_msg_decrypt
// Description : Bench for msg_decrypt with an RC4 reference model and memories.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_msg_decrypt;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start_a [3];
  logic [7:0] sq, rq;
  logic [7:0] o_sa [3], o_sd [3], o_ra [3], o_da [3], o_dd [3];
  logic       o_sw [3], o_dw [3], o_dmh [3], o_fin [3], o_ki [3];
  logic [1:0] o_ms [3];

  // Instances 0/1/2 carry MSG_LEN 1/32/256.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    msg_decrypt_if bus ();
    assign bus.state_start = start_a[g];
    assign bus.s_q         = sq;
    assign bus.rom_q       = rq;
    msg_decrypt #(.MSG_LEN(g == 0 ? 1 : (g == 1 ? 32 : 256))) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign o_sa[g]  = bus.s_address;
    assign o_sd[g]  = bus.s_data;
    assign o_sw[g]  = bus.s_wen;
    assign o_ra[g]  = bus.rom_address;
    assign o_da[g]  = bus.d_address;
    assign o_dd[g]  = bus.d_data;
    assign o_dw[g]  = bus.d_wen;
    assign o_ms[g]  = bus.memory_sel;
    assign o_dmh[g] = bus.dec_mem_handler;
    assign o_fin[g] = bus.finish;
    assign o_ki[g]  = bus.key_invalid;
  end

  int          tests = 0, fails = 0;
  int          cur = 0;
  int          d_pulses = 0;
  bit          run_on = 1'b0;
  bit          load = 1'b0;
  logic [7:0]  smem [256], rom [256], dmem [256];
  logic [7:0]  s_init [256], rom_img [256], ptb [256], m_s [256];
  logic [7:0]  m_i, m_j;
  logic [15:0] exp_d [$], exp_s [$];
  logic [15:0] e_s, e_d;
  bit          exp_invalid;
  int          exp_bytes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit printable(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
  endfunction

  function automatic logic [31:0] outs_a(input int g);
    return {o_sa[g], o_sd[g], o_ra[g], o_da[g]};
  endfunction

  function automatic logic [31:0] outs_b(input int g);
    return {17'd0, o_dd[g], o_sw[g], o_dw[g], o_ms[g], o_dmh[g], o_fin[g], o_ki[g]};
  endfunction

  // Synchronous RAM/ROM: address sampled on an edge, data visible after it.
  always @(posedge clk) begin
    if (load) begin
      for (int x = 0; x < 256; x++) begin
        smem[x] <= s_init[x];
        rom[x]  <= rom_img[x];
        dmem[x] <= 8'h00;
      end
    end else begin
      sq <= smem[o_sa[cur]];
      rq <= rom[o_ra[cur]];
      if (o_sw[cur]) smem[o_sa[cur]] <= o_sd[cur];
      if (o_dw[cur]) dmem[o_da[cur]] <= o_dd[cur];
    end
  end

  // Every write strobe must match the next write the RC4 model predicts.
  always @(negedge clk) begin
    if (rst_n && run_on) begin
      chk("wen_exclusive", {31'd0, o_sw[cur] & o_dw[cur]}, 32'd0);
      if (o_sw[cur]) begin
        if (exp_s.size() == 0) begin
          tests++; fails++;
          $display("FAIL s_write_extra: addr %0h data %0h, none expected", o_sa[cur], o_sd[cur]);
        end else begin
          e_s = exp_s.pop_front();
          chk("s_write", {16'd0, o_sa[cur], o_sd[cur]}, {16'd0, e_s});
        end
      end
      if (o_dw[cur]) begin
        d_pulses++;
        if (exp_d.size() == 0) begin
          tests++; fails++;
          $display("FAIL d_write_extra: addr %0h data %0h, none expected", o_da[cur], o_dd[cur]);
        end else begin
          e_d = exp_d.pop_front();
          chk("d_write", {16'd0, o_da[cur], o_dd[cur]}, {16'd0, e_d});
        end
      end
    end
  end

  task automatic prga_step(output logic [7:0] ks);
    logic [7:0] t, idx;
    m_i = m_i + 8'd1;
    m_j = m_j + m_s[m_i];
    exp_s.push_back({m_i, m_s[m_j]});
    exp_s.push_back({m_j, m_s[m_i]});
    t = m_s[m_i]; m_s[m_i] = m_s[m_j]; m_s[m_j] = t;
    idx = m_s[m_i] + m_s[m_j];
    ks = m_s[idx];
  endtask

  task automatic model_build(input int len);
    logic [7:0] ks, o;
    exp_d.delete(); exp_s.delete();
    m_i = 8'd0; m_j = 8'd0; exp_invalid = 1'b0;
    for (int k = 0; k < len; k++) begin
      prga_step(ks);
      o = ks ^ rom_img[k];
      exp_d.push_back({k[7:0], o});
      if (!printable(o)) begin exp_invalid = 1'b1; break; end
    end
    exp_bytes = exp_d.size();
  endtask

  task automatic copy_init();
    for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
  endtask

  task automatic identity_s();
    for (int x = 0; x < 256; x++) s_init[x] = x[7:0];
  endtask

  task automatic shuffle_s();
    logic [7:0] t;
    int r;
    identity_s();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
    end
  endtask

  task automatic enc_rom(input int n);
    logic [7:0] ks;
    for (int x = 0; x < 256; x++) rom_img[x] = 8'h00;
    copy_init();
    m_i = 8'd0; m_j = 8'd0;
    for (int k = 0; k < n; k++) begin
      prga_step(ks);
      rom_img[k] = ptb[k] ^ ks;
    end
    exp_s.delete();
  endtask

  task automatic set_pt_string();
    string pt;
    pt = "thequickbrownfoxjumpsoverthelazy";
    for (int k = 0; k < 32; k++) ptb[k] = pt[k];
  endtask

  task automatic load_mem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic pulse_start(input int g);
    start_a[g] = 1'b1;
    @(negedge clk);
    start_a[g] = 1'b0;
    chk("start_state", {27'd0, o_dmh[g], o_ms[g], o_fin[g], o_ki[g]}, 32'b11000);
  endtask

  task automatic wait_done(input int g, input int budget, output int cyc);
    cyc = 0;
    while (!o_fin[g] && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic final_checks(input int g, input int cyc);
    int diffs;
    chk("cycles", cyc, 13 * exp_bytes);
    chk("finish", {31'd0, o_fin[g]}, 32'd1);
    chk("key_invalid", {31'd0, o_ki[g]}, {31'd0, exp_invalid});
    chk("done_bus", {29'd0, o_dmh[g], o_ms[g]}, 32'd0);
    chk("s_left", exp_s.size(), 0);
    chk("d_left", exp_d.size(), 0);
    chk("d_pulses", d_pulses, exp_bytes);
    diffs = 0;
    for (int x = 0; x < 256; x++) if (smem[x] !== m_s[x]) diffs++;
    chk("final_s_diffs", diffs, 0);
    repeat (3) @(negedge clk);
    chk("finish_held", {31'd0, o_fin[g]}, 32'd1);
  endtask

  task automatic run(input int g, input int len, output int cyc);
    load_mem();
    cur = g; d_pulses = 0; run_on = 1'b1;
    pulse_start(g);
    wait_done(g, 13 * len + 40, cyc);
    final_checks(g, cyc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, bad;
    logic [15:0] tmp;
    logic [31:0] acc;
    for (int g = 0; g < 3; g++) start_a[g] = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_outs_a", outs_a(g), 32'd0);
      chk("reset_outs_b", outs_b(g), 32'd0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int g = 0; g < 3; g++) chk("idle_outs_b", outs_b(g), 32'd0);

    // Identity S, single byte 0x63 -> 'a'
    identity_s();
    for (int x = 0; x < 256; x++) rom_img[x] = 8'h00;
    rom_img[0] = 8'h63;
    copy_init(); model_build(1);
    chk("model_d0", {16'd0, exp_d[0]}, 32'h0061);
    chk("model_s0", {16'd0, exp_s[0]}, 32'h0101);
    chk("model_s1", {16'd0, exp_s[1]}, 32'h0101);
    run(0, 1, cyc);
    chk("len1_cycles", cyc, 13);
    chk("len1_dmem0", {24'd0, dmem[0]}, 32'h61);
    chk("len1_key_invalid", {31'd0, o_ki[0]}, 32'd0);

    // Identity S, zero ROM -> 0x02 is non-printable, abort after one byte
    for (int x = 0; x < 256; x++) rom_img[x] = 8'h00;
    copy_init(); model_build(32);
    chk("model_inv_bytes", exp_bytes, 1);
    run(1, 32, cyc);
    chk("inv_dmem0", {24'd0, dmem[0]}, 32'h02);
    chk("inv_key_invalid", {31'd0, o_ki[1]}, 32'd1);
    chk("inv_pulses", d_pulses, 1);
    chk("inv_memory_sel", {30'd0, o_ms[1]}, 32'd0);

    // Random permutation, 32-letter plaintext
    shuffle_s(); set_pt_string(); enc_rom(32);
    copy_init(); model_build(32);
    run(1, 32, cyc);
    chk("pt_cycles", cyc, 416);
    bad = 0;
    for (int k = 0; k < 32; k++) if (dmem[k] !== ptb[k]) bad++;
    chk("pt_diffs", bad, 0);
    chk("pt_key_invalid", {31'd0, o_ki[1]}, 32'd0);

    // 256 spaces, i wraps 255 -> 0 on the last byte
    shuffle_s();
    for (int k = 0; k < 256; k++) ptb[k] = 8'h20;
    enc_rom(256);
    copy_init(); model_build(256);
    tmp = exp_s[510];
    chk("model_i_wrap", {24'd0, tmp[15:8]}, 32'd0);
    run(2, 256, cyc);
    chk("space_cycles", cyc, 3328);
    bad = 0;
    for (int k = 0; k < 256; k++) if (dmem[k] !== 8'h20) bad++;
    chk("space_diffs", bad, 0);
    chk("space_key_invalid", {31'd0, o_ki[2]}, 32'd0);

    // Restart mid-run at the start of byte 5
    shuffle_s(); set_pt_string(); enc_rom(32);
    copy_init(); model_build(32);
    load_mem();
    cur = 1; d_pulses = 0; run_on = 1'b1;
    pulse_start(1);
    cyc = 0;
    while (cyc < 64) begin @(negedge clk); cyc++; end
    #1 chk("pre_restart_d_left", exp_d.size(), 27);
    start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    for (int x = 0; x < 256; x++) m_s[x] = smem[x];
    model_build(32);
    d_pulses = 0;
    chk("restart_state", {27'd0, o_dmh[1], o_ms[1], o_fin[1], o_ki[1]}, 32'b11000);
    wait_done(1, 13 * 32 + 40, cyc);
    final_checks(1, cyc);

    // Fresh run, asynchronous reset while the byte-10 S write strobe is high
    shuffle_s(); set_pt_string(); enc_rom(32);
    copy_init(); model_build(32);
    load_mem();
    cur = 1; d_pulses = 0;
    pulse_start(1);
    cyc = 0;
    while (cyc < 137) begin @(negedge clk); cyc++; end
    chk("wen_before_reset", {31'd0, o_sw[1]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs_a", outs_a(1), 32'd0);
    chk("async_reset_outs_b", outs_b(1), 32'd0);
    run_on = 1'b0;
    exp_s.delete(); exp_d.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc = 32'd0;
    repeat (20) begin
      @(negedge clk);
      acc = acc | outs_a(1) | outs_b(1);
    end
    chk("idle_after_reset", acc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
